// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one cache line as critical-beat-first wrapping bursts
// and assembles it for the data array write path and the word selector.
module line_fill_buffer #(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fill_req,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic                  fill_cancel,
  output logic                  fill_busy,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_resp,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  crit_valid,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic [ADDR_WIDTH-1:0] line_addr,
  output logic                  line_valid
);

  localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_W = $clog2(BEAT_WIDTH / 8);
  localparam int OFF_W  = IDX_W + BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        beat_idx_reg, beat_idx_next;
  logic [IDX_W-1:0]        beat_cnt_reg, beat_cnt_next;
  logic [ADDR_WIDTH-1:0]   line_addr_reg, line_addr_next;
  logic                    crit_valid_reg, crit_valid_next;
  logic                    start_fill;
  logic                    beat_accept;
  logic                    last_beat;
  logic                    unused_addr_bits;

  // A cancel in the same cycle as a response discards that beat entirely.
  assign start_fill  = (state_reg == ST_IDLE) && fill_req;
  assign beat_accept = (state_reg == ST_REQ) && mem_resp && !fill_cancel;
  assign last_beat   = beat_accept && (beat_cnt_reg == IDX_W'(BEATS - 1));

  assign unused_addr_bits = ^fill_addr[BYTE_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fill_req) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fill_cancel) begin
          state_next = ST_IDLE;
        end else if (last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_read   = 1'b0;
    fill_busy  = 1'b0;
    line_valid = 1'b0;
    case (state_reg)
      ST_REQ: begin
        mem_read  = 1'b1;
        fill_busy = 1'b1;
      end
      ST_DONE: begin
        fill_busy  = 1'b1;
        line_valid = 1'b1;
      end
      default: begin
        mem_read   = 1'b0;
        fill_busy  = 1'b0;
        line_valid = 1'b0;
      end
    endcase
  end

  // Beat index wraps naturally at the line boundary (BEATS is a power of two).
  always_comb begin
    beat_idx_next   = beat_idx_reg;
    beat_cnt_next   = beat_cnt_reg;
    line_addr_next  = line_addr_reg;
    crit_valid_next = beat_accept && (beat_cnt_reg == '0);
    if (start_fill) begin
      beat_idx_next  = fill_addr[OFF_W-1:BYTE_W];
      beat_cnt_next  = '0;
      line_addr_next = {fill_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    end else if (beat_accept) begin
      beat_idx_next = beat_idx_reg + IDX_W'(1);
      beat_cnt_next = beat_cnt_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_idx_reg   <= '0;
      beat_cnt_reg   <= '0;
      line_addr_reg  <= '0;
      crit_valid_reg <= 1'b0;
    end else begin
      beat_idx_reg   <= beat_idx_next;
      beat_cnt_reg   <= beat_cnt_next;
      line_addr_reg  <= line_addr_next;
      crit_valid_reg <= crit_valid_next;
    end
  end

  // One storage lane per beat; only the lane addressed by the beat index loads.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      logic [BEAT_WIDTH-1:0] lane_reg;
      logic                  lane_we;

      assign lane_we = beat_accept && (beat_idx_reg == IDX_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lane_reg <= '0;
        end else if (lane_we) begin
          lane_reg <= mem_rdata;
        end
      end

      assign line_out[gi*BEAT_WIDTH +: BEAT_WIDTH] = lane_reg;
    end
  endgenerate

  assign mem_addr   = {line_addr_reg[ADDR_WIDTH-1:OFF_W], beat_idx_reg, {BYTE_W{1'b0}}};
  assign line_addr  = line_addr_reg;
  assign crit_valid = crit_valid_reg;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: directed fills with literal expectations plus
// randomized fills checked every cycle against a beat-counting reference model.
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         fill_cancel;
  logic         fill_busy;
  logic         mem_read;
  logic [15:0]  mem_addr;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         crit_valid;
  logic [127:0] line_out;
  logic [15:0]  line_addr;
  logic         line_valid;

  always #5 clk = ~clk;

  line_fill_buffer #(
    .LINE_WIDTH(128),
    .BEAT_WIDTH(32),
    .ADDR_WIDTH(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_cancel(fill_cancel),
    .fill_busy  (fill_busy),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .crit_valid (crit_valid),
    .line_out   (line_out),
    .line_addr  (line_addr),
    .line_valid (line_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a fill is "active" until four beats land or it is cancelled;
  // the beat address is the start beat plus beats received, modulo four.
  bit           m_active;
  bit           m_lv;
  bit           m_crit;
  int           m_k;
  int           m_start;
  logic [15:0]  m_base;
  logic [127:0] m_line;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_lv     <= 1'b0;
      m_crit   <= 1'b0;
      m_k      <= 0;
      m_start  <= 0;
      m_base   <= '0;
      m_line   <= '0;
    end else begin
      m_lv   <= 1'b0;
      m_crit <= 1'b0;
      if (!m_active && !m_lv && fill_req) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_base   <= fill_addr & 16'hFFF0;
        m_start  <= int'(fill_addr[3:2]);
      end else if (m_active) begin
        if (fill_cancel) begin
          m_active <= 1'b0;
        end else if (mem_resp) begin
          m_line[((m_start + m_k) % 4) * 32 +: 32] <= mem_rdata;
          m_k <= m_k + 1;
          if (m_k == 0) m_crit <= 1'b1;
          if (m_k == 3) begin
            m_active <= 1'b0;
            m_lv     <= 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("fill_busy", 128'(fill_busy), 128'(m_active || m_lv));
    chk("mem_read", 128'(mem_read), 128'(m_active));
    chk("line_valid", 128'(line_valid), 128'(m_lv));
    chk("crit_valid", 128'(crit_valid), 128'(m_crit));
    chk("line_addr", 128'(line_addr), 128'(m_base));
    if (m_active)
      chk("mem_addr", 128'(mem_addr), 128'(m_base + 16'(((m_start + m_k) % 4) * 4)));
    if (m_lv)
      chk("line_out", line_out, m_line);
  end

  // Driver helpers and per-fill observations
  logic [31:0] bdata [4];
  logic [15:0] seen_addr [4];
  int obs_crit, obs_lv, obs_lv_at, c0, fill_no;

  task automatic step();
    @(posedge clk);
    #1;
    if (crit_valid) obs_crit++;
    if (line_valid) begin
      obs_lv++;
      obs_lv_at = cyc;
    end
  endtask

  // stall < 0 means random stalls; cancel_beat < 0 means no cancel.
  task automatic do_fill(input logic [15:0] addr, input int stall, input int cancel_beat,
                         input bit intrude);
    int  ns;
    bit  stop;
    obs_crit  = 0;
    obs_lv    = 0;
    obs_lv_at = -1;
    stop      = 1'b0;
    fill_req  = 1'b1;
    fill_addr = addr;
    step();
    c0        = cyc;
    fill_req  = intrude;
    fill_addr = intrude ? 16'h7000 : 16'($urandom);
    for (int b = 0; b < 4 && !stop; b++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < ns; s++) begin
        mem_resp    = 1'b0;
        mem_rdata   = $urandom;
        fill_cancel = 1'b0;
        step();
      end
      seen_addr[b] = mem_addr;
      mem_resp     = 1'b1;
      mem_rdata    = bdata[b];
      fill_cancel  = (b == cancel_beat);
      step();
      mem_resp    = 1'b0;
      mem_rdata   = $urandom;
      if (b == cancel_beat) begin
        fill_cancel = 1'b0;
        fill_req    = 1'b0;
        stop        = 1'b1;
      end
    end
    if (!stop) begin
      fill_cancel = 1'($urandom % 2);
      step();
      fill_cancel = 1'b0;
      fill_req    = 1'b0;
    end
    step();
    fill_no++;
    $display("fill %0d addr=%h cancel_beat=%0d intrude=%0d crit_pulses=%0d line_valid_pulses=%0d line_out=%h",
             fill_no, addr, cancel_beat, intrude, obs_crit, obs_lv, line_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cb;
    fill_no     = 0;
    reset_n     = 1'b0;
    fill_req    = 1'b0;
    fill_addr   = '0;
    fill_cancel = 1'b0;
    mem_resp    = 1'b0;
    mem_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_read", 128'(mem_read), 128'(0));
    chk("reset mem_addr", 128'(mem_addr), 128'(0));
    chk("reset fill_busy", 128'(fill_busy), 128'(0));
    chk("reset crit_valid", 128'(crit_valid), 128'(0));
    chk("reset line_valid", 128'(line_valid), 128'(0));
    chk("reset line_out", line_out, 128'(0));
    chk("reset line_addr", 128'(line_addr), 128'(0));
    reset_n = 1'b1;
    step();

    // Aligned fill, zero wait
    bdata = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    do_fill(16'h1230, 0, -1, 1'b0);
    chk("t1 addr0", 128'(seen_addr[0]), 128'(16'h1230));
    chk("t1 addr1", 128'(seen_addr[1]), 128'(16'h1234));
    chk("t1 addr2", 128'(seen_addr[2]), 128'(16'h1238));
    chk("t1 addr3", 128'(seen_addr[3]), 128'(16'h123C));
    chk("t1 lv count", 128'(obs_lv), 128'(1));
    chk("t1 lv cycle", 128'(obs_lv_at - c0), 128'(4));
    chk("t1 line_out", line_out, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    chk("t1 line_addr", 128'(line_addr), 128'(16'h1230));

    // Critical-word-first wrap: beats land at word 2,3,0,1
    bdata = '{32'h22222222, 32'h33333333, 32'h00000000, 32'h11111111};
    do_fill(16'h20AA, 0, -1, 1'b0);
    chk("t2 addr0", 128'(seen_addr[0]), 128'(16'h20A8));
    chk("t2 addr1", 128'(seen_addr[1]), 128'(16'h20AC));
    chk("t2 addr2", 128'(seen_addr[2]), 128'(16'h20A0));
    chk("t2 addr3", 128'(seen_addr[3]), 128'(16'h20A4));
    chk("t2 line_out", line_out, 128'h33333333_22222222_11111111_00000000);
    chk("t2 crit pulses", 128'(obs_crit), 128'(1));

    // Stalled memory: three idle cycles before each beat
    bdata = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    do_fill(16'h4000, 3, -1, 1'b0);
    chk("t3 lv count", 128'(obs_lv), 128'(1));
    chk("t3 lv cycle", 128'(obs_lv_at - c0), 128'(16));
    chk("t3 line_out", line_out, 128'h0D0E0F10_090A0B0C_05060708_01020304);

    // Cancel together with the final response, then a clean fill
    bdata = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
    do_fill(16'h3000, 0, 3, 1'b0);
    chk("t4 lv count", 128'(obs_lv), 128'(0));
    chk("t4 busy after cancel", 128'(fill_busy), 128'(0));
    bdata = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    do_fill(16'h5550, 0, -1, 1'b0);
    chk("t4 refill lv count", 128'(obs_lv), 128'(1));
    chk("t4 refill line_addr", 128'(line_addr), 128'(16'h5550));

    // Request at 0x7000 held during a fill is ignored
    bdata = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
    do_fill(16'h6004, 1, -1, 1'b1);
    chk("t5 addr0", 128'(seen_addr[0]), 128'(16'h6004));
    chk("t5 addr1", 128'(seen_addr[1]), 128'(16'h6008));
    chk("t5 addr2", 128'(seen_addr[2]), 128'(16'h600C));
    chk("t5 addr3", 128'(seen_addr[3]), 128'(16'h6000));
    chk("t5 line_addr", 128'(line_addr), 128'(16'h6000));

    // Asynchronous reset pulse mid-fill, between clock edges
    obs_lv    = 0;
    fill_req  = 1'b1;
    fill_addr = 16'h6100;
    step();
    fill_req  = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_rdata = 32'hFEEDFACE;
    step();
    mem_resp  = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async rst mem_read", 128'(mem_read), 128'(0));
    chk("async rst fill_busy", 128'(fill_busy), 128'(0));
    chk("async rst line_out", line_out, 128'(0));
    #1 reset_n = 1'b1;
    repeat (6) begin
      mem_resp  = 1'b1;
      mem_rdata = $urandom;
      step();
    end
    mem_resp = 1'b0;
    chk("async rst no lv", 128'(obs_lv), 128'(0));
    $display("reset pulse mid-fill: line_valid_pulses=%0d", obs_lv);

    // Randomized fills with stalls, cancels, intruding requests and idle noise
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < 4; b++) bdata[b] = $urandom;
      cb = ($urandom % 5 == 0) ? int'($urandom_range(0, 3)) : -1;
      do_fill(16'($urandom), -1, cb, 1'($urandom % 3 == 0));
      repeat ($urandom_range(0, 2)) begin
        fill_cancel = 1'($urandom % 2);
        mem_resp    = 1'($urandom % 2);
        mem_rdata   = $urandom;
        step();
      end
      fill_cancel = 1'b0;
      mem_resp    = 1'b0;
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
